// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the accumulator CPU fetch path: opcode encodings, field widths, IR slices.
// Optional feature macro used by the fetch unit files: FETCH_BRKPT_EN.
package risc_pkg;

    localparam int OPC_W       = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 13;

    localparam logic [OPC_W-1:0] HLT = 3'b000;
    localparam logic [OPC_W-1:0] SKZ = 3'b001;
    localparam logic [OPC_W-1:0] ADD = 3'b010;
    localparam logic [OPC_W-1:0] AND = 3'b011;
    localparam logic [OPC_W-1:0] XOR = 3'b100;
    localparam logic [OPC_W-1:0] LDA = 3'b101;
    localparam logic [OPC_W-1:0] STO = 3'b110;
    localparam logic [OPC_W-1:0] JMP = 3'b111;

    // Instruction word layout: opcode in the top bits, operand address below it.
    localparam int IR_W       = 2 * DATA_W_DEF;
    localparam int IR_OPC_HI  = IR_W - 1;
    localparam int IR_OPC_LO  = IR_W - OPC_W;
    localparam int IR_ADDR_HI = IR_W - OPC_W - 1;
    localparam int IR_ADDR_LO = 0;

    typedef enum logic {
        PHASE_HI = 1'b0,
        PHASE_LO = 1'b1
    } byte_phase_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: control strobes and memory data in from the FSM side, IR/PC/address out.
// FETCH_BRKPT_EN adds the breakpoint compare signals.
interface instr_fetch_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
);
    import risc_pkg::*;

    logic [DATA_W-1:0] data;
    logic              ld_ir;
    logic              ld_pc;
    logic              inc_pc;
    logic              sel;
    logic              halt;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] addr;
    logic              ir_valid;
`ifdef FETCH_BRKPT_EN
    logic              brk_en;
    logic [ADDR_W-1:0] brk_addr;
    logic              brk_hit;

    modport master (
        output data, ld_ir, ld_pc, inc_pc, sel, halt, brk_en, brk_addr,
        input  opcode, ir_addr, pc_addr, addr, ir_valid, brk_hit
    );

    modport slave (
        input  data, ld_ir, ld_pc, inc_pc, sel, halt, brk_en, brk_addr,
        output opcode, ir_addr, pc_addr, addr, ir_valid, brk_hit
    );
`else
    modport master (
        output data, ld_ir, ld_pc, inc_pc, sel, halt,
        input  opcode, ir_addr, pc_addr, addr, ir_valid
    );

    modport slave (
        input  data, ld_ir, ld_pc, inc_pc, sel, halt,
        output opcode, ir_addr, pc_addr, addr, ir_valid
    );
`endif

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: halt holds, otherwise load beats increment; increment wraps silently.
module pc_counter #(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (!halt) begin
            if (ld_pc)
                pc_d = load_val;
            else if (inc_pc)
                pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pc_q <= PC_RESET;
        else
            pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch datapath: two-byte instruction assembly into IR, PC, and memory address mux.
// Define FETCH_BRKPT_EN to add a sticky PC breakpoint flag.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input logic               clock,
    input logic               reset,
    instr_fetch_unit_if.slave bus
);

    localparam int IRW = 2 * DATA_W;

    if (ADDR_W != IRW - OPC_W) begin : g_bad_addr_w
        $error("instr_fetch_unit: ADDR_W must equal 2*DATA_W-3");
    end

    logic [IRW-1:0]    ir_q;
    logic [IRW-1:0]    ir_d;
    byte_phase_e       phase_q;
    byte_phase_e       phase_d;
    logic              ir_valid_q;
    logic              ir_valid_d;
    logic              cap_en;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;

    assign cap_en  = bus.ld_ir && !bus.halt;
    assign ir_addr = ir_q[ADDR_W-1:0];

    always_comb begin
        ir_d       = ir_q;
        phase_d    = phase_q;
        ir_valid_d = ir_valid_q;
        if (cap_en) begin
            if (phase_q == PHASE_HI) begin
                ir_d[IRW-1:DATA_W] = bus.data;
                phase_d            = PHASE_LO;
                ir_valid_d         = 1'b0;
            end else begin
                ir_d[DATA_W-1:0] = bus.data;
                phase_d          = PHASE_HI;
                ir_valid_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_q       <= '0;
            phase_q    <= PHASE_HI;
            ir_valid_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            phase_q    <= phase_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // PC loads from the pre-edge IR, so a same-cycle ld_ir never leaks into the jump target.
    pc_counter #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .halt     (bus.halt),
        .ld_pc    (bus.ld_pc),
        .inc_pc   (bus.inc_pc),
        .load_val (ir_addr),
        .pc       (pc_addr)
    );

    assign bus.opcode   = ir_q[IRW-1 -: OPC_W];
    assign bus.ir_addr  = ir_addr;
    assign bus.pc_addr  = pc_addr;
    assign bus.addr     = bus.sel ? pc_addr : ir_addr;
    assign bus.ir_valid = ir_valid_q;

`ifdef FETCH_BRKPT_EN
    logic brk_hit_q;

    // Fires on the edge that completes the instruction word; stays set until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            brk_hit_q <= 1'b0;
        else if (cap_en && (phase_q == PHASE_LO) && bus.brk_en && (pc_addr == bus.brk_addr))
            brk_hit_q <= 1'b1;
    end

    assign bus.brk_hit = brk_hit_q;
`endif

endmodule
